// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB4 master port among NREQ requesters.
// Sequences SETUP/ACCESS phases, generates odd byte parity, and returns status to the winner.
module apb_master_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 256
) (
  input  logic              apbclk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*24-1:0] addr_i,
  input  logic [NREQ*32-1:0] wdata_i,
  input  logic [NREQ*4-1:0]  strb_i,
  input  logic [NREQ-1:0]   write_i,
  output logic [NREQ-1:0]   done_o,
  output logic [31:0]       rdata_o,
  output logic              slverr_o,
  output logic              timeout_o,
  output logic              par_err_o,
  output logic              busy_o,
  output logic [23:0]       APB_PADDR,
  output logic              APB_PSEL,
  output logic              APB_PENABLE,
  output logic              APB_PWRITE,
  output logic [31:0]       APB_PWDATA,
  output logic [3:0]        APB_PWDATA_PAR,
  output logic [3:0]        APB_PSTRB,
  output logic              APB_PSTRB_PAR,
  input  logic [31:0]       APB_PRDATA,
  input  logic [3:0]        APB_PRDATA_PAR,
  input  logic              APB_PREADY,
  input  logic              APB_PSLVERR
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : '0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]      state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   win;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;
  logic            found;
  logic [31:0]     cnt;
  logic            acc_end;
  logic [23:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic [3:0]      sel_strb;
  logic            sel_wr;
  logic [31:0]     nxt_wdata;
  logic [3:0]      nxt_strb;
  logic [NREQ-1:0] win_oh;

  function automatic logic [3:0] byte_par(input logic [31:0] d);
    logic [3:0] p;
    p = '0;
    for (int unsigned k = 0; k < 4; k++) p[k] = ~^d[8*k +: 8];
    return p;
  endfunction

  // Scan starts one past the last winner so the previous owner is checked last.
  always_comb begin
    pick  = last;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = IW'((32'(last) + off) % 32'(NREQ));
      if (!found && req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    sel_wr    = 1'b0;
    win_oh    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IW'(i) == pick) begin
        sel_addr  = addr_i[i*24 +: 24];
        sel_wdata = wdata_i[i*32 +: 32];
        sel_strb  = strb_i[i*4 +: 4];
        sel_wr    = write_i[i];
      end
      win_oh[i] = (IW'(i) == win);
    end
    nxt_wdata = sel_wr ? sel_wdata : '0;
    nxt_strb  = sel_wr ? sel_strb  : '0;
    acc_end   = APB_PREADY || ((TIMEOUT != 0) && (cnt == TO_LAST));
  end

  assign busy_o = (state != S_IDLE);

  always_ff @(posedge apbclk) begin
    if (!rstn) begin
      state          <= S_IDLE;
      last           <= IW'(NREQ - 1);
      win            <= '0;
      cnt            <= '0;
      done_o         <= '0;
      rdata_o        <= '0;
      slverr_o       <= 1'b0;
      timeout_o      <= 1'b0;
      par_err_o      <= 1'b0;
      APB_PADDR      <= '0;
      APB_PSEL       <= 1'b0;
      APB_PENABLE    <= 1'b0;
      APB_PWRITE     <= 1'b0;
      APB_PWDATA     <= '0;
      APB_PWDATA_PAR <= '0;
      APB_PSTRB      <= '0;
      APB_PSTRB_PAR  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            win            <= pick;
            APB_PADDR      <= sel_addr;
            APB_PSEL       <= 1'b1;
            APB_PENABLE    <= 1'b0;
            APB_PWRITE     <= sel_wr;
            APB_PWDATA     <= nxt_wdata;
            APB_PWDATA_PAR <= byte_par(nxt_wdata);
            APB_PSTRB      <= nxt_strb;
            APB_PSTRB_PAR  <= ~^nxt_strb;
            state          <= S_SETUP;
          end
        end
        S_SETUP: begin
          APB_PENABLE <= 1'b1;
          cnt         <= '0;
          state       <= S_ACCESS;
        end
        S_ACCESS: begin
          if (acc_end) begin
            if (APB_PREADY) begin
              rdata_o   <= APB_PWRITE ? '0 : APB_PRDATA;
              slverr_o  <= APB_PSLVERR;
              par_err_o <= !APB_PWRITE && (APB_PRDATA_PAR != byte_par(APB_PRDATA));
            end else begin
              timeout_o <= 1'b1;
              slverr_o  <= 1'b1;
              rdata_o   <= '0;
            end
            // Idle-bus parity reflects the all-zero data/strobe being driven.
            done_o         <= win_oh;
            APB_PSEL       <= 1'b0;
            APB_PENABLE    <= 1'b0;
            APB_PWRITE     <= 1'b0;
            APB_PWDATA     <= '0;
            APB_PWDATA_PAR <= 4'hF;
            APB_PSTRB      <= '0;
            APB_PSTRB_PAR  <= 1'b1;
            state          <= S_DONE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          done_o    <= '0;
          rdata_o   <= '0;
          slverr_o  <= 1'b0;
          timeout_o <= 1'b0;
          par_err_o <= 1'b0;
          last      <= win;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: expected setups/results are queued at
// stimulus time and compared when the DUT starts a transfer or pulses done_o.
module tb_apb_master_arbiter;

  localparam int NREQ = 2;

  logic              apbclk = 1'b0;
  logic              rstn;
  logic [NREQ-1:0]   req_i;
  logic [NREQ*24-1:0] addr_i;
  logic [NREQ*32-1:0] wdata_i;
  logic [NREQ*4-1:0]  strb_i;
  logic [NREQ-1:0]   write_i;
  logic [NREQ-1:0]   done_o;
  logic [31:0]       rdata_o;
  logic              slverr_o, timeout_o, par_err_o, busy_o;
  logic [23:0]       APB_PADDR;
  logic              APB_PSEL, APB_PENABLE, APB_PWRITE;
  logic [31:0]       APB_PWDATA;
  logic [3:0]        APB_PWDATA_PAR, APB_PSTRB;
  logic              APB_PSTRB_PAR;
  logic [31:0]       APB_PRDATA;
  logic [3:0]        APB_PRDATA_PAR;
  logic              APB_PREADY, APB_PSLVERR;

  apb_master_arbiter #(.NREQ(NREQ), .TIMEOUT(8)) dut (
    .apbclk(apbclk), .rstn(rstn), .req_i(req_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .strb_i(strb_i), .write_i(write_i), .done_o(done_o),
    .rdata_o(rdata_o), .slverr_o(slverr_o), .timeout_o(timeout_o),
    .par_err_o(par_err_o), .busy_o(busy_o), .APB_PADDR(APB_PADDR),
    .APB_PSEL(APB_PSEL), .APB_PENABLE(APB_PENABLE), .APB_PWRITE(APB_PWRITE),
    .APB_PWDATA(APB_PWDATA), .APB_PWDATA_PAR(APB_PWDATA_PAR),
    .APB_PSTRB(APB_PSTRB), .APB_PSTRB_PAR(APB_PSTRB_PAR),
    .APB_PRDATA(APB_PRDATA), .APB_PRDATA_PAR(APB_PRDATA_PAR),
    .APB_PREADY(APB_PREADY), .APB_PSLVERR(APB_PSLVERR)
  );

  always #5 apbclk = ~apbclk;

  typedef struct {
    int unsigned idx;
    logic [23:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } setup_t;

  typedef struct {
    int unsigned idx;
    logic [31:0] rdata;
    logic        slverr;
    logic        tmo;
    logic        perr;
    int unsigned nacc;
  } res_t;

  setup_t setup_q[$];
  res_t   res_q[$];
  setup_t cur;
  res_t   r;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned acc_n  = 0;
  int unsigned hold_left = 0;
  logic [NREQ-1:0] prev_done = '0;

  // Slave model controls
  int unsigned sl_lat   = 0;
  int unsigned sl_cnt   = 0;
  logic        sl_stuck = 1'b0;
  logic        sl_err   = 1'b0;
  logic [31:0] sl_rdata = '0;
  logic [3:0]  sl_flip  = '0;

  function automatic logic [3:0] opar(input logic [31:0] d);
    logic [3:0] p;
    for (int k = 0; k < 4; k++) p[k] = (($countones(d[8*k +: 8]) % 2) == 0);
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  assign APB_PRDATA     = sl_rdata;
  assign APB_PRDATA_PAR = opar(sl_rdata) ^ sl_flip;
  assign APB_PSLVERR    = sl_err;

  task automatic expect_xfer(input int unsigned k, input logic [23:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic w, input logic [31:0] rd,
                             input logic se, input logic to, input logic pe, input int unsigned na);
    setup_t su;
    res_t   rs;
    su.idx = k; su.addr = a; su.wr = w; su.wdata = d; su.strb = s;
    rs.idx = k; rs.rdata = rd; rs.slverr = se; rs.tmo = to; rs.perr = pe; rs.nacc = na;
    setup_q.push_back(su);
    res_q.push_back(rs);
  endtask

  task automatic drive_req(input int unsigned k, input logic [23:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic w);
    addr_i[k*24 +: 24]  = a;
    wdata_i[k*32 +: 32] = d;
    strb_i[k*4 +: 4]    = s;
    write_i[k]          = w;
    req_i[k]            = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (res_q.size() == 0 && setup_q.size() == 0 && !busy_o) break;
      @(posedge apbclk);
    end
    if (res_q.size() != 0 || setup_q.size() != 0 || busy_o) begin
      check("wait_bound", res_q.size() + setup_q.size(), 0);
      res_q.delete();
      setup_q.delete();
    end
    @(negedge apbclk);
  endtask

  // Monitor and APB slave, evaluated away from the active edge
  always @(negedge apbclk) begin
    if (prev_done != '0) check("done_width", done_o, 0);
    if (APB_PSEL && !APB_PENABLE) begin
      if (setup_q.size() == 0) check("spurious_setup", 1, 0);
      else begin
        cur = setup_q.pop_front();
        check("setup_addr", APB_PADDR, cur.addr);
        check("setup_write", APB_PWRITE, cur.wr);
        check("setup_wdata", APB_PWDATA, cur.wr ? cur.wdata : 32'h0);
        check("setup_wpar", APB_PWDATA_PAR, opar(cur.wr ? cur.wdata : 32'h0));
        check("setup_strb", APB_PSTRB, cur.wr ? cur.strb : 4'h0);
        check("setup_spar", APB_PSTRB_PAR,
              ($countones(cur.wr ? cur.strb : 4'h0) % 2) == 0);
      end
      acc_n = 0;
    end
    if (APB_PSEL && APB_PENABLE) begin
      acc_n++;
      check("hold_addr", APB_PADDR, cur.addr);
      check("hold_strb", APB_PSTRB, cur.wr ? cur.strb : 4'h0);
    end
    if (done_o != '0) begin
      check("done_psel", APB_PSEL, 0);
      if (res_q.size() == 0) check("spurious_done", done_o, 0);
      else begin
        r = res_q.pop_front();
        check("done_onehot", done_o, 32'(1) << r.idx);
        check("rdata", rdata_o, r.rdata);
        check("slverr", slverr_o, r.slverr);
        check("timeout", timeout_o, r.tmo);
        check("par_err", par_err_o, r.perr);
        check("access_cycles", acc_n, r.nacc);
      end
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) req_i = '0;
      end else begin
        req_i = req_i & ~done_o;
      end
    end
    prev_done = done_o;
    if (APB_PSEL && APB_PENABLE) begin
      APB_PREADY = (sl_cnt >= sl_lat) && !sl_stuck;
      sl_cnt++;
    end else begin
      APB_PREADY = 1'b0;
      sl_cnt = 0;
    end
  end

  initial begin
    rstn = 1'b0; req_i = '0; addr_i = '0; wdata_i = '0; strb_i = '0; write_i = '0;
    APB_PREADY = 1'b0;
    repeat (3) @(posedge apbclk);
    #1;
    check("rst_psel", {APB_PSEL, APB_PENABLE, APB_PWRITE}, 0);
    check("rst_paddr", APB_PADDR, 0);
    check("rst_par", {APB_PWDATA_PAR, APB_PSTRB_PAR}, 0);
    check("rst_done", {done_o, slverr_o, timeout_o, par_err_o, busy_o}, 0);
    @(negedge apbclk);
    rstn = 1'b1;
    @(negedge apbclk);

    // Single write, PREADY immediate
    expect_xfer(0, 24'h000010, 32'hA5A5_0F0F, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    drive_req(0, 24'h000010, 32'hA5A5_0F0F, 4'hF, 1'b1);
    @(posedge apbclk); #1;
    check("t1_setup", {APB_PSEL, APB_PENABLE}, 2'b10);
    check("t1_busy", busy_o, 1);
    check("t1_wpar", APB_PWDATA_PAR, 4'b1111);
    @(posedge apbclk); #1;
    check("t1_access", {APB_PSEL, APB_PENABLE}, 2'b11);
    wait_idle();

    // Read with 3 wait states
    sl_lat = 3; sl_rdata = 32'h1234_5678;
    expect_xfer(1, 24'h000200, 32'hDEAD_BEEF, 4'hC, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 4);
    drive_req(1, 24'h000200, 32'hDEAD_BEEF, 4'hC, 1'b0);
    wait_idle();

    // Both requesters held high for four transfers
    sl_lat = 0;
    for (int n = 0; n < 2; n++) begin
      expect_xfer(0, 24'h000100, 32'h1111_2222, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1);
      expect_xfer(1, 24'h000104, 32'h3333_4444, 4'h3, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    end
    hold_left = 4;
    drive_req(0, 24'h000100, 32'h1111_2222, 4'hF, 1'b1);
    drive_req(1, 24'h000104, 32'h3333_4444, 4'h3, 1'b1);
    wait_idle();
    hold_left = 0;

    // Stuck slave aborts after 8 ACCESS cycles, then a normal transfer
    sl_stuck = 1'b1; sl_rdata = 32'h7777_8888;
    expect_xfer(0, 24'h000300, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 8);
    drive_req(0, 24'h000300, 32'h0, 4'h0, 1'b0);
    wait_idle();
    sl_stuck = 1'b0;
    expect_xfer(1, 24'h000304, 32'h5A5A_5A5A, 4'h5, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    drive_req(1, 24'h000304, 32'h5A5A_5A5A, 4'h5, 1'b1);
    wait_idle();

    // Bad read parity, then slave error on a write
    sl_rdata = 32'hCAFE_F00D; sl_flip = 4'b0100;
    expect_xfer(0, 24'h000308, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1, 1);
    drive_req(0, 24'h000308, 32'h0, 4'h0, 1'b0);
    wait_idle();
    sl_flip = 4'b0000; sl_err = 1'b1;
    expect_xfer(1, 24'h00030C, 32'h0102_0304, 4'h7, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1);
    drive_req(1, 24'h00030C, 32'h0102_0304, 4'h7, 1'b1);
    wait_idle();
    sl_err = 1'b0;

    // Reset during ACCESS: no done pulse, requester 0 wins afterwards
    sl_stuck = 1'b1;
    begin
      setup_t su;
      su.idx = 0; su.addr = 24'h000400; su.wr = 1'b0; su.wdata = '0; su.strb = '0;
      setup_q.push_back(su);
    end
    drive_req(0, 24'h000400, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (APB_PENABLE) break;
      @(negedge apbclk);
    end
    check("rst_reach_access", APB_PENABLE, 1);
    rstn = 1'b0; req_i = '0;
    @(posedge apbclk); #1;
    check("midrst_apb", {APB_PSEL, APB_PENABLE, APB_PWRITE, APB_PSTRB, APB_PSTRB_PAR}, 0);
    check("midrst_paddr", APB_PADDR, 0);
    check("midrst_wpar", APB_PWDATA_PAR, 0);
    check("midrst_done", {done_o, busy_o}, 0);
    @(negedge apbclk);
    rstn = 1'b1; sl_stuck = 1'b0; sl_rdata = 32'h0BAD_F00D;
    expect_xfer(0, 24'h000500, 32'h8000_0001, 4'h9, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    expect_xfer(1, 24'h000504, 32'h0, 4'h0, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0, 1);
    drive_req(0, 24'h000500, 32'h8000_0001, 4'h9, 1'b1);
    drive_req(1, 24'h000504, 32'h0, 4'h0, 1'b0);
    wait_idle();
    check("end_idle", {busy_o, APB_PSEL}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
